alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: n, default 32, datapath width in bits; legal range n >= 17.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  n  operand A.
REQ-005 Port: b  input  n  operand B.
REQ-006 Port: af  input  4  ALU function select.
REQ-007 Port: i  input  1  immediate-instruction qualifier; only affects af=0111.
REQ-008 Port: alures  output  n  registered ALU result.
REQ-009 Port: ovfalu  output  1  registered signed-overflow flag.

Function
REQ-010 The block SHALL compute a combinational result from a, b, af and i, and register it into alures/ovfalu on every rising clk edge; latency exactly 1 cycle, no enable, no stall.
REQ-011 af=0000 add: alures = (a+b) mod 2^n; ovfalu = 1 iff a and b have equal sign bits and the sum's sign differs.
REQ-012 af=0001 unsigned add: alures = (a+b) mod 2^n; ovfalu = 0.
REQ-013 af=0010 sub: alures = (a-b) mod 2^n; ovfalu = 1 iff a and b have different sign bits and the difference's sign differs from a.
REQ-014 af=0011 unsigned sub: alures = (a-b) mod 2^n; ovfalu = 0.
REQ-015 af=0100: a AND b; af=0101: a OR b; af=0110: a XOR b; ovfalu = 0.
REQ-016 af=0111, i=0: alures = NOT (a OR b); i=1: alures = {b[15:0], (n-16) zeros} (load-upper); ovfalu = 0.
REQ-017 af=1010 signed less-than: alures = all ones when a < b as two's-complement, else all zeros; ovfalu = 0.
REQ-018 af=1011 unsigned less-than: as REQ-017 with unsigned comparison (see REQ-024).
REQ-019 All other af codes (1000, 1001, 11xx): alures = 0, ovfalu = 0.
REQ-020 Carry-out is discarded; no carry, zero or negative outputs exist.
REQ-021 ovfalu SHALL be 0 for every code other than 0000 and 0010, independent of i.

Reset
REQ-022 While rst_n = 0, alures = 0 and ovfalu = 0 immediately, independent of clk.
REQ-023 On rst_n deassertion, the first rising clk edge loads the result of current inputs; reset asserted mid-stream discards the pending result.

Configuration
REQ-024 Macro ALU_SLTU_EN: when defined, af=1011 performs unsigned less-than per REQ-018; when undefined, af=1011 behaves as REQ-019 (alures = 0, ovfalu = 0). All other codes are unaffected.

Verification
REQ-025 Add: a=000000A5, b=0000005A, af=0000, i=0, one clk edge -> alures=000000FF, ovfalu=0; sub af=0010 same operands -> 0000004B, 0.
REQ-026 Logic: a=AAAAAAAA, b=55555555 -> af=0100: 00000000; 0101: FFFFFFFF; 0110: FFFFFFFF; 0111,i=0: 00000000; ovfalu=0 throughout.
REQ-027 Load-upper: a=AAAAAAAA, b=55555555, af=0111, i=1 -> alures=55550000, ovfalu=0.
REQ-028 Compare: a=00000001, b=00000002, af=1010 -> FFFFFFFF; a=FFFFFFFF, b=00000001, af=1010 -> FFFFFFFF, af=1011 -> 00000000 (with ALU_SLTU_EN), 00000000 without.
REQ-029 Overflow: a=7FFFFFFF, b=00000001, af=0000 -> 80000000, ovfalu=1; same with af=0001 -> 80000000, ovfalu=0; a=80000000, b=00000001, af=0010 -> 7FFFFFFF, ovfalu=1.
REQ-030 Reset: drive rst_n=0 between clk edges after a nonzero result -> alures=0, ovfalu=0 without waiting for clk; outputs stay 0 until first edge after release.

Source files
------------

// File: rtl/alu.sv
// Single-cycle registered ALU: add/sub with signed overflow, logic ops, load-upper, set-less-than.
// Optional feature: define ALU_SLTU_EN to enable unsigned set-less-than on af=1011.
module alu #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [3:0]   af,
  input  logic         i,
  output logic [n-1:0] alures,
  output logic         ovfalu
);

  typedef struct packed {
    logic [n-1:0] res;
    logic         ovf;
  } alu_rsp_t;

  logic [n-1:0] sum, diff;
  logic         ovf_add, ovf_sub, slt, sltu;
  alu_rsp_t     rsp_d;

  assign sum  = a + b;
  assign diff = a - b;

  // Overflow only when the operand signs make the true result unrepresentable.
  assign ovf_add = (a[n-1] == b[n-1]) && (sum[n-1]  != a[n-1]);
  assign ovf_sub = (a[n-1] != b[n-1]) && (diff[n-1] != a[n-1]);
  assign slt     = $signed(a) < $signed(b);
  assign sltu    = a < b;

  always_comb begin
    rsp_d = '0;
    unique case (af)
      4'b0000: begin rsp_d.res = sum; rsp_d.ovf = ovf_add; end
      4'b0001: rsp_d.res = sum;
      4'b0010: begin rsp_d.res = diff; rsp_d.ovf = ovf_sub; end
      4'b0011: rsp_d.res = diff;
      4'b0100: rsp_d.res = a & b;
      4'b0101: rsp_d.res = a | b;
      4'b0110: rsp_d.res = a ^ b;
      4'b0111: rsp_d.res = i ? {b[15:0], {(n-16){1'b0}}} : ~(a | b);
      4'b1010: rsp_d.res = {n{slt}};
`ifdef ALU_SLTU_EN
      4'b1011: rsp_d.res = {n{sltu}};
`endif
      default: rsp_d = '0;
    endcase
  end

`ifndef ALU_SLTU_EN
  logic unused_sltu;
  assign unused_sltu = sltu;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alures <= '0;
      ovfalu <= 1'b0;
    end else begin
      alures <= rsp_d.res;
      ovfalu <= rsp_d.ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, random vectors against a
// wide-integer reference model, and reset corner sequences; scoreboard queue.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  af = '0;
  logic        i = 1'b0;
  logic [31:0] alures;
  logic        ovfalu;

  int n_cmp = 0;
  int n_bad = 0;

  alu #(.n(32)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .af(af), .i(i),
    .alures(alures), .ovfalu(ovfalu)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  af;
    logic        i;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          id;
  } exp_t;

  exp_t sb[$];

  // Reference model using 64-bit signed arithmetic and range checks.
  function automatic void model(input logic [31:0] ma, mb, input logic [3:0] maf,
                                input logic mi, output logic [31:0] r, output logic o);
    longint sa, sb_, s;
    sa = longint'($signed(ma));
    sb_ = longint'($signed(mb));
    r = '0; o = 1'b0;
    case (maf)
      4'd0: begin s = sa + sb_; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa + sb_; r = s[31:0]; end
      4'd2: begin s = sa - sb_; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: begin s = sa - sb_; r = s[31:0]; end
      4'd4: r = ma & mb;
      4'd5: r = ma | mb;
      4'd6: r = ma ^ mb;
      4'd7: r = mi ? (mb << 16) : ~(ma | mb);
      4'd10: r = (sa < sb_) ? 32'hFFFF_FFFF : 32'h0;
`ifdef ALU_SLTU_EN
      4'd11: r = (ma < mb) ? 32'hFFFF_FFFF : 32'h0;
`endif
      default: r = '0;
    endcase
  endfunction

  task automatic check(input string nm, input int id, input logic [31:0] got_r, input logic got_o,
                       input logic [31:0] exp_r, input logic exp_o);
    n_cmp++;
    if (got_r !== exp_r || got_o !== exp_o) begin
      n_bad++;
      $display("FAIL %s #%0d: got res=%08h ovf=%b, want res=%08h ovf=%b",
               nm, id, got_r, got_o, exp_r, exp_o);
    end
  endtask

  // Drive between edges, push expectation, compare just after the capturing edge.
  task automatic apply(input logic [31:0] va, vb, input logic [3:0] vaf, input logic vi,
                       input logic [31:0] er, input logic eo, input int id, input string nm);
    exp_t e;
    @(negedge clk);
    a = va; b = vb; af = vaf; i = vi;
    e.res = er; e.ovf = eo; e.id = id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      check(nm, e.id, alures, ovfalu, e.res, e.ovf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] r;
    logic o;

    tbl.push_back('{32'h000000A5, 32'h0000005A, 4'b0000, 1'b0, 32'h000000FF, 1'b0});
    tbl.push_back('{32'h000000A5, 32'h0000005A, 4'b0010, 1'b0, 32'h0000004B, 1'b0});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 4'b0100, 1'b0, 32'h00000000, 1'b0});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 4'b0101, 1'b0, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 4'b0110, 1'b0, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 4'b0111, 1'b0, 32'h00000000, 1'b0});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 4'b0111, 1'b1, 32'h55550000, 1'b0});
    tbl.push_back('{32'h00000001, 32'h00000002, 4'b1010, 1'b0, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'h00000001, 4'b1010, 1'b0, 32'hFFFFFFFF, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'h00000001, 4'b1011, 1'b0, 32'h00000000, 1'b0});
`ifdef ALU_SLTU_EN
    tbl.push_back('{32'h00000001, 32'hFFFFFFFF, 4'b1011, 1'b0, 32'hFFFFFFFF, 1'b0});
`else
    tbl.push_back('{32'h00000001, 32'hFFFFFFFF, 4'b1011, 1'b0, 32'h00000000, 1'b0});
`endif
    tbl.push_back('{32'h7FFFFFFF, 32'h00000001, 4'b0000, 1'b0, 32'h80000000, 1'b1});
    tbl.push_back('{32'h7FFFFFFF, 32'h00000001, 4'b0001, 1'b0, 32'h80000000, 1'b0});
    tbl.push_back('{32'h80000000, 32'h00000001, 4'b0010, 1'b0, 32'h7FFFFFFF, 1'b1});
    tbl.push_back('{32'h80000000, 32'h00000001, 4'b0011, 1'b0, 32'h7FFFFFFF, 1'b0});
    tbl.push_back('{32'h80000000, 32'h80000000, 4'b0000, 1'b0, 32'h00000000, 1'b1});
    tbl.push_back('{32'h00000000, 32'h80000000, 4'b0010, 1'b0, 32'h80000000, 1'b1});
    tbl.push_back('{32'h12345678, 32'h9ABCDEF0, 4'b1000, 1'b1, 32'h00000000, 1'b0});
    tbl.push_back('{32'h12345678, 32'h9ABCDEF0, 4'b1001, 1'b0, 32'h00000000, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111, 1'b1, 32'h00000000, 1'b0});
    tbl.push_back('{32'h00000005, 32'hFFFFFFFF, 4'b1010, 1'b0, 32'h00000000, 1'b0});
    tbl.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0110, 1'b1, 32'h00000000, 1'b0});

    // Reset state, asynchronous, before any clock edge.
    #2;
    check("reset_init", 0, alures, ovfalu, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k])
      apply(tbl[k].a, tbl[k].b, tbl[k].af, tbl[k].i, tbl[k].res, tbl[k].ovf, k, "vec");

    for (int k = 0; k < 200; k++) begin
      logic [31:0] ra, rb;
      logic [3:0]  raf;
      logic        ri;
      ra = $urandom; rb = $urandom; raf = 4'($urandom_range(0, 15)); ri = 1'($urandom);
      if (k % 4 == 0) begin ra[31] = 1'b0; rb[31] = 1'b0; ra[30] = 1'b1; rb[30] = 1'b1; end
      model(ra, rb, raf, ri, r, o);
      apply(ra, rb, raf, ri, r, o, k, "rand");
    end

    // Async reset mid-cycle after an overflowing result.
    apply(32'h7FFFFFFF, 32'h00000001, 4'b0000, 1'b0, 32'h80000000, 1'b1, 0, "pre_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 0, alures, ovfalu, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("rst_hold", 0, alures, ovfalu, 32'h0, 1'b0);

    // Release with new inputs; stays 0 until the first edge, then loads them.
    @(negedge clk);
    a = 32'h000000A5; b = 32'h0000005A; af = 4'b0000; i = 1'b0;
    rst_n = 1'b1;
    #1 check("rst_release_pre_edge", 0, alures, ovfalu, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("rst_first_edge", 0, alures, ovfalu, 32'h000000FF, 1'b0);

    // Reset asserted while a result is pending discards it.
    @(negedge clk);
    a = 32'h80000000; b = 32'h00000001; af = 4'b0010;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_discard", 0, alures, ovfalu, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h80000000, 32'h00000001, 4'b0010, 1'b0, 32'h7FFFFFFF, 1'b1, 0, "post_rst");

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
